// File: rtl/prbs7_pkg.sv
// Shared PRBS-7 definitions: feedback taps, checker state encoding and
// default lock/loss-of-lock constants.
package prbs7_pkg;

    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    localparam int DEF_LOCK_CNT   = 16;
    localparam int DEF_WIN_LEN    = 128;
    localparam int DEF_LOL_THRESH = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Next PRBS-7 bit (x^7 + x^6 + 1) from the last seven bits, s[0] newest.
    function automatic logic prbs7_pred(input logic [6:0] s);
        return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// Bundle of the checker's serial input, control and result signals.
// The master side feeds bits in, the slave side (the checker) reports results.
interface prbs7_checker_if #(
    parameter int CNT_W = 32
);
    logic             data_in;
    logic             data_valid;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic             sync_lost;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] first_err_pos;

    modport master (
        output data_in, data_valid, clear_counts,
        input  locked, err_pulse, sync_lost, err_count, bit_count, first_err_pos
    );

    modport slave (
        input  data_in, data_valid, clear_counts,
        output locked, err_pulse, sync_lost, err_count, bit_count, first_err_pos
    );
endinterface

// File: rtl/prbs7_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module prbs7_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receive checker with error/bit counting and loss-of-lock.
// Define PRBS7_CHK_FIRST_ERR_EN to build first-error bit position capture.
module prbs7_checker
    import prbs7_pkg::*;
#(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int LOL_THRESH = DEF_LOL_THRESH,
    parameter int CNT_W      = 32
) (
    input  logic          clock,
    input  logic          reset,
    prbs7_checker_if.slave bus
);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WB_W    = $clog2(WIN_LEN + 1);
    localparam int WE_W    = $clog2(LOL_THRESH + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WB_W-1:0]    WB_LAST    = WB_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0]    WE_LAST    = WE_W'(LOL_THRESH - 1);

    chk_state_t         state_reg, state_next;
    logic [6:0]         s_reg, s_next;
    logic [2:0]         fill_reg, fill_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic [WB_W-1:0]    win_bits_reg, win_bits_next;
    logic [WE_W-1:0]    win_errs_reg, win_errs_next;
    logic               locked_reg, err_pulse_reg, sync_lost_reg;

    logic               pred;
    logic [6:0]         shifted;
    logic               err_hit;
    logic               bit_hit;
    logic               lol;

    assign pred    = prbs7_pred(s_reg);
    assign shifted = {s_reg[5:0], bus.data_in};

    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        fill_next     = fill_reg;
        match_next    = match_reg;
        win_bits_next = win_bits_reg;
        win_errs_next = win_errs_reg;
        err_hit       = 1'b0;
        bit_hit       = 1'b0;
        lol           = 1'b0;

        if (bus.data_valid) begin
            case (state_reg)
                SEARCH: begin
                    s_next = shifted;
                    if (fill_reg == 3'd6) begin
                        fill_next = '0;
                        // An all-zero register is the LFSR lock-up state: keep filling.
                        if (shifted != '0) begin
                            state_next = VERIFY;
                            match_next = '0;
                        end
                    end else begin
                        fill_next = fill_reg + 3'd1;
                    end
                end
                VERIFY: begin
                    if (bus.data_in == pred) begin
                        s_next     = shifted;
                        match_next = match_reg + MATCH_W'(1);
                        if (match_reg == MATCH_LAST) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        state_next = SEARCH;
                        fill_next  = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a received error never propagates.
                    s_next  = {s_reg[5:0], pred};
                    bit_hit = 1'b1;
                    err_hit = (bus.data_in != pred);
                    if (err_hit && (win_errs_reg == WE_LAST)) begin
                        lol           = 1'b1;
                        state_next    = SEARCH;
                        fill_next     = '0;
                        win_bits_next = '0;
                        win_errs_next = '0;
                    end else if (win_bits_reg == WB_LAST) begin
                        win_bits_next = '0;
                        win_errs_next = '0;
                    end else begin
                        win_bits_next = win_bits_reg + WB_W'(1);
                        win_errs_next = win_errs_reg + WE_W'(err_hit);
                    end
                end
                default: begin
                    state_next = SEARCH;
                    fill_next  = '0;
                end
            endcase
        end

        if (bus.clear_counts) begin
            win_bits_next = '0;
            win_errs_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= SEARCH;
            s_reg         <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            win_bits_reg  <= '0;
            win_errs_reg  <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            sync_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            win_bits_reg  <= win_bits_next;
            win_errs_reg  <= win_errs_next;
            locked_reg    <= (state_next == LOCKED);
            err_pulse_reg <= err_hit;
            sync_lost_reg <= lol;
        end
    end

    // Index 0 counts errors, index 1 counts checked bits.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {bit_hit, err_hit};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        prbs7_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (cnt_inc[gi]),
            .clr   (bus.clear_counts),
            .count (cnt_val[gi])
        );
    end

    assign bus.err_count = cnt_val[0];
    assign bus.bit_count = cnt_val[1];
    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.sync_lost = sync_lost_reg;

`ifdef PRBS7_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] first_pos_reg;
    logic             first_seen_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_pos_reg  <= '0;
            first_seen_reg <= 1'b0;
        end else if (bus.clear_counts) begin
            first_pos_reg  <= '0;
            first_seen_reg <= 1'b0;
        end else if (err_hit && !first_seen_reg) begin
            first_pos_reg  <= cnt_val[1];
            first_seen_reg <= 1'b1;
        end
    end

    assign bus.first_err_pos = first_pos_reg;
`else
    assign bus.first_err_pos = '0;
`endif

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side PRBS-7 checker for the integrated BERT; the other end of the PRBS-7 LFSR generator.
- Polynomial x^7+x^6+1, serial 1 bit per valid cycle.
- Self-synchronises to the incoming stream, then counts bit errors and checked bits.
- Raises loss-of-sync when the error density exceeds a threshold.
- Sits after the receive path and before the BERT result registers and display.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions needed in VERIFY before LOCKED.
- WIN_LEN, 128: loss-of-lock window length, in valid bits.
- LOL_THRESH, 16: errors within one window that force resync.
- CNT_W, 32: width of the error and bit counters.

Ports:
- clock  in  1: single rising-edge clock.
- reset  in  1: asynchronous, active-low reset (asserted at 0).
- data_in  in  1: received serial bit.
- data_valid  in  1: data_in is valid this cycle; all state advances only when high.
- clear_counts  in  1: synchronous clear of err_count, bit_count, and the window.
- locked  out  1: checker is in LOCKED.
- err_pulse  out  1: one-cycle pulse per detected error while LOCKED.
- sync_lost  out  1: one-cycle pulse on the LOCKED->SEARCH transition.
- err_count  out  CNT_W: errors counted while LOCKED; saturating.
- bit_count  out  CNT_W: valid bits checked while LOCKED; saturating.
- first_err_pos  out  CNT_W: see Optional Feature.

Behaviour:
- Reset values: all outputs 0. State SEARCH, shift register s[6:0]=0, fill counter 0, window counters 0.
- Prediction: pred = s[6]^s[5]. Advance: s <= {s[5:0], x}.
- All outputs are registered. Effects of a valid bit appear on the next clock edge (latency 1).
- With data_valid=0 nothing changes, and pulses are 0.
- SEARCH:
  - Each valid bit: x=data_in; fill++.
  - At the 7th fill bit: if the resulting s != 0, go to VERIFY with match count 0.
  - If the resulting s == 0, restart the fill (the all-zero stream never locks).
- VERIFY:
  - data_in==pred: x=data_in; match++.
  - When match reaches LOCK_CNT, go to LOCKED and assert locked.
  - Mismatch: go to SEARCH, fill=0 (the mismatching bit is discarded).
  - VERIFY bits are not counted.
- LOCKED:
  - x=pred (free-running; received errors are not fed back, so there is no error multiplication).
  - bit_count++ on every valid bit.
  - data_in!=pred: err_count++, err_pulse=1, window error count++.
  - Window: at each WIN_LEN valid bits the window bit and error counters both reset to 0.
  - If the window error count reaches LOL_THRESH, on that same edge: go to SEARCH, locked=0, sync_lost=1, fill=0, window cleared.
  - err_count and bit_count hold their values across the transition.
- Saturation: err_count and bit_count stop at all-ones and never wrap.
- clear_counts:
  - Zeroes err_count, bit_count, the window counters, and first_err_pos.
  - Has priority over a simultaneous increment; the result is 0.
  - Does not change state or s.
- Reset asserted mid-operation immediately returns every register to its reset value.

Optional Feature:
- Macro PRBS7_CHK_FIRST_ERR_EN.
- Defined: first_err_pos captures the value of bit_count at the first error after reset or clear_counts. Later errors leave it unchanged until the next clear.
- Undefined: no capture logic is built, and first_err_pos is tied to 0.

Decomposition:
- Package prbs7_pkg holds:
  - PRBS7_TAP_HI=6 and PRBS7_TAP_LO=5;
  - the state typedef chk_state_t {SEARCH, VERIFY, LOCKED};
  - the default constants for LOCK_CNT, WIN_LEN, and LOL_THRESH.
- One natural sub-module: prbs7_sat_counter (CNT_W, inc, clr, saturating), instantiated for err_count and bit_count.

Test Plan:
- Clean PRBS-7 stream from seed 7'h7F, data_valid=1. Expected: locked rises on the edge after the 23rd bit (7 fill + 16 verify), err_count=0, bit_count=100 after 100 further bits.
- Locked, then invert exactly one bit. Expected: err_pulse high for 1 cycle, err_count=1, locked stays 1.
- Locked, then invert 16 consecutive bits. Expected: sync_lost pulse on the 16th, locked=0; clean data then relocks after 23 bits; err_count stays 16 across the relock.
- All-zero input for 200 bits. Expected: locked never asserts.
- Clean stream with data_valid toggling 1/0. Expected: lock reached after 23 valid bits regardless of gaps; bit_count counts only valid cycles.
- Assert clear_counts together with an error bit. Expected: err_count=0.
- Reset low mid-LOCKED. Expected: all outputs 0 immediately.
- With PRBS7_CHK_FIRST_ERR_EN: first error at bit_count=37. Expected: first_err_pos=37, unchanged by later errors.
